// File: rtl/uart_tx_buffer.sv
// Byte FIFO between a CPU memory bus and uart_tx: writes queue the low data byte,
// reads return FIFO status, and a drain FSM hands bytes to uart_tx one frame at a time.

typedef struct packed {
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
} mem_in_type;

typedef struct packed {
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;
} mem_out_type;

module uart_tx_buffer #(
  parameter int depth = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  bus_in,
  output mem_out_type bus_out,
  output mem_in_type  tx_in,
  input  mem_out_type tx_out
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  logic [7:0]       mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       pend_data_q, pend_data_d;
  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic             push, pop;
  logic [7:0]       push_data;
  logic             fifo_full, fifo_empty, busy, accept;

  logic unused_inputs;
  assign unused_inputs = ^{bus_in.mem_instr, bus_in.mem_addr, bus_in.mem_wdata[31:8],
                           tx_out.mem_rdata, tx_out.mem_error};

  assign fifo_full  = (count_q == CNT_W'(depth));
  assign fifo_empty = (count_q == '0);
  assign busy       = (state_q != IDLE);
  // A request seen while its own response is on the bus is the same request, not a new one.
  assign accept     = bus_in.mem_valid && !pend_valid_q && !ready_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    state_d      = state_q;
    ready_d      = 1'b0;
    rdata_d      = 32'h0;
    tx_valid_d   = 1'b0;
    tx_data_d    = 8'h0;
    push         = 1'b0;
    pop          = 1'b0;
    push_data    = pend_data_q;

    if (pend_valid_q) begin
      if (!fifo_full) begin
        push         = 1'b1;
        pend_valid_d = 1'b0;
        ready_d      = 1'b1;
      end
    end else if (accept) begin
      if (|bus_in.mem_wstrb) begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = bus_in.mem_wdata[7:0];
          ready_d   = 1'b1;
        end else begin
          pend_valid_d = 1'b1;
          pend_data_d  = bus_in.mem_wdata[7:0];
        end
      end else begin
        ready_d = 1'b1;
        rdata_d = {16'h0, 8'(count_q), 5'h0, busy, fifo_empty, fifo_full};
      end
    end

    // The head byte is captured on entry to SEND so tx_in is driven straight from flops.
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d    = SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
        end
      end
      SEND: begin
        pop     = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_out.mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      rdata_q      <= 32'h0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      state_q      <= state_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
    end
  end

  always_ff @(posedge clock) begin
    pend_data_q <= pend_data_d;
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign bus_out.mem_ready = ready_q;
  assign bus_out.mem_rdata = rdata_q;
  assign bus_out.mem_error = 1'b0;

  assign tx_in.mem_valid = tx_valid_q;
  assign tx_in.mem_instr = 1'b0;
  assign tx_in.mem_addr  = 32'h0;
  assign tx_in.mem_wdata = {24'h0, tx_data_q};
  assign tx_in.mem_wstrb = {3'b000, tx_valid_q};

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized scoreboard bench for uart_tx_buffer: drivers queue expected bus responses
// and transmitted bytes, a negedge monitor pops and compares them against the DUT.

module tb_uart_tx_buffer;

  localparam int DEPTH = 4;
  localparam int LIMIT = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  mem_in_type  bus_in;
  mem_out_type bus_out;
  mem_in_type  tx_in;
  mem_out_type tx_out;

  uart_tx_buffer #(.depth(DEPTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_in (bus_in),
    .bus_out(bus_out),
    .tx_in  (tx_in),
    .tx_out (tx_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    int          due;
    bit          is_wr;
  } bus_exp_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } tx_exp_t;

  bus_exp_t exp_bus[$];
  tx_exp_t  exp_tx[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int n_resp = 0, n_wr_done = 0, n_tx_seen = 0, base = 0;
  int last_resp_cyc = -1, last_tx_cyc = -1, last_ack_cyc = -1;
  bit prev_tx_valid = 0;
  bit ack_hold = 1, ack_rand = 0, b2b_chk = 0;
  int ack_fixed = 0;
  int manual_req = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference status word built from the model's notion of occupancy.
  function automatic logic [31:0] status_of(input int cnt, input bit bsy);
    logic [31:0] s;
    s = 32'h0;
    s[15:8] = 8'(cnt);
    s[2] = bsy;
    s[1] = (cnt == 0);
    s[0] = (cnt == DEPTH);
    return s;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // uart_tx stand-in: acks a request after a fixed/random delay, or only on demand.
  initial begin
    bit waiting;
    int wait_n;
    int manual_done;
    waiting = 0; wait_n = 0; manual_done = 0;
    tx_out = '0;
    forever begin
      @(posedge clock); #1;
      tx_out.mem_ready = 1'b0;
      if (reset) waiting = 0;
      else if (tx_in.mem_valid) begin
        waiting = 1;
        wait_n  = ack_rand ? int'($urandom_range(0, 10)) : ack_fixed;
      end else if (waiting) begin
        if (manual_done != manual_req) begin
          tx_out.mem_ready = 1'b1;
          manual_done++;
          waiting = 0;
        end else if (!ack_hold) begin
          if (wait_n == 0) begin
            tx_out.mem_ready = 1'b1;
            waiting = 0;
          end else wait_n--;
        end
      end
    end
  end

  // Monitor: compares every bus response and every transmitted byte.
  initial forever begin
    bus_exp_t e;
    tx_exp_t  t;
    @(negedge clock);
    if (!reset) begin
      if (bus_out.mem_ready) begin
        if (exp_bus.size() == 0) chk("bus_unexpected_ready", 32'd1, 32'd0);
        else begin
          e = exp_bus.pop_front();
          if (!e.is_wr) chk("status_rdata", bus_out.mem_rdata, e.rdata);
          if (e.due >= 0) chk("bus_ready_cycle", cyc, e.due);
          if (e.is_wr) n_wr_done++;
        end
        n_resp++;
        last_resp_cyc = cyc;
      end else if (bus_out.mem_rdata !== 32'h0) begin
        chk("rdata_without_ready", bus_out.mem_rdata, 32'h0);
      end
      if (bus_out.mem_error !== 1'b0) chk("mem_error", 32'(bus_out.mem_error), 32'h0);

      if (tx_in.mem_valid) begin
        chk("tx_valid_consecutive", 32'(prev_tx_valid), 32'd0);
        chk("tx_wstrb", 32'(tx_in.mem_wstrb), 32'h1);
        if (exp_tx.size() == 0) chk("tx_unexpected_byte", tx_in.mem_wdata, 32'hFFFF_FFFF);
        else begin
          t = exp_tx.pop_front();
          chk("tx_wdata", tx_in.mem_wdata, {24'h0, t.data});
          if (t.due >= 0) chk("tx_valid_cycle", cyc, t.due);
        end
        if (b2b_chk && last_ack_cyc >= 0) chk("tx_after_ack", cyc, last_ack_cyc + 2);
        n_tx_seen++;
        last_tx_cyc = cyc;
      end
      if (tx_out.mem_ready) last_ack_cyc = cyc;
      prev_tx_valid = tx_in.mem_valid;
    end
  end

  task automatic wait_resp(input int target, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < LIMIT; i++) begin
      if (n_resp >= target) begin ok = 1; break; end
      @(posedge clock); #1;
    end
    if (!ok) chk({nm, "_timeout"}, n_resp, target);
  endtask

  task automatic wait_tx(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < LIMIT; i++) begin
      if (n_tx_seen >= target) begin ok = 1; break; end
      @(posedge clock); #1;
    end
    if (!ok) chk("tx_timeout", n_tx_seen, target);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < LIMIT; i++) begin
      if (exp_tx.size() == 0) begin ok = 1; break; end
      @(posedge clock); #1;
    end
    if (!ok) chk("drain_timeout", exp_tx.size(), 0);
  endtask

  task automatic issue_write(input logic [7:0] b, input int lat_rdy, input int lat_tx);
    bus_exp_t e;
    tx_exp_t  t;
    @(posedge clock); #1;
    e.rdata = 32'h0; e.is_wr = 1;
    e.due   = (lat_rdy < 0) ? -1 : cyc + lat_rdy;
    t.data  = b;
    t.due   = (lat_tx < 0) ? -1 : cyc + lat_tx;
    exp_bus.push_back(e);
    exp_tx.push_back(t);
    bus_in.mem_valid = 1'b1;
    bus_in.mem_wstrb = 4'(1 + $urandom_range(0, 14));
    bus_in.mem_wdata = {24'($urandom), b};
    @(posedge clock); #1;
    bus_in = '0;
  endtask

  task automatic do_write(input logic [7:0] b, input int lat_rdy, input int lat_tx);
    int target;
    target = n_resp + 1;
    issue_write(b, lat_rdy, lat_tx);
    wait_resp(target, "write");
  endtask

  task automatic do_read(input bit bsy);
    bus_exp_t e;
    int target;
    @(posedge clock); #1;
    target  = n_resp + 1;
    e.rdata = status_of(n_wr_done - n_tx_seen - base, bsy);
    e.due   = cyc + 1;
    e.is_wr = 0;
    exp_bus.push_back(e);
    bus_in.mem_valid = 1'b1;
    bus_in.mem_wstrb = 4'h0;
    bus_in.mem_wdata = $urandom;
    @(posedge clock); #1;
    bus_in = '0;
    wait_resp(target, "read");
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_bus_ready"}, 32'(bus_out.mem_ready), 32'h0);
    chk({nm, "_bus_rdata"}, bus_out.mem_rdata, 32'h0);
    chk({nm, "_tx_valid"}, 32'(tx_in.mem_valid), 32'h0);
    chk({nm, "_tx_wdata"}, tx_in.mem_wdata, 32'h0);
    chk({nm, "_tx_wstrb"}, 32'(tx_in.mem_wstrb), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, txs0;
    bus_in = '0;

    // Reset and idle
    repeat (2) @(posedge clock);
    #1 chk_outputs_zero("reset");
    @(posedge clock); #3 reset = 1'b0;
    repeat (3) @(posedge clock);
    do_read(1'b0);

    // Single write, ack withheld until the bench releases it
    ack_hold = 1;
    do_write(8'h41, 1, 2);
    wait_tx(1);
    repeat (5) @(posedge clock);
    do_read(1'b1);
    manual_req++;
    repeat (4) @(posedge clock);
    do_read(1'b0);

    // Burst with a uart_tx that acks 20 cycles after each request
    ack_fixed = 19; ack_rand = 0; ack_hold = 0;
    for (int i = 0; i < 5; i++) do_write(8'h30 + 8'(i), (i == 0) ? 1 : -1, (i == 0) ? 2 : -1);
    b2b_chk = 1;
    wait_tx(n_tx_seen + 1);
    do_read(1'b1);
    wait_drain();
    repeat (25) @(posedge clock);
    b2b_chk = 0;
    do_read(1'b0);

    // Fill while the ack is withheld, then a write that must wait for space
    ack_hold = 1; ack_fixed = 2;
    for (int i = 0; i < 5; i++) do_write(8'h50 + 8'(i), 1, -1);
    repeat (3) @(posedge clock);
    do_read(1'b1);
    r0 = n_resp;
    issue_write(8'hA5, -1, -1);
    repeat (10) @(posedge clock);
    #1 chk("full_write_no_ready", n_resp, r0);
    manual_req++;
    wait_resp(r0 + 1, "full_write");
    chk("full_write_ready_after_pop", last_resp_cyc, last_tx_cyc + 2);
    ack_hold = 0;
    wait_drain();
    repeat (15) @(posedge clock);
    do_read(1'b0);

    // Wrap-around stream with random ack delays
    ack_rand = 1;
    for (int i = 0; i < 3 * DEPTH; i++) do_write(8'($urandom), -1, -1);
    wait_drain();
    repeat (20) @(posedge clock);
    do_read(1'b0);

    // Asynchronous reset mid-cycle while a byte is being offered, FIFO full, write pending
    ack_rand = 0; ack_hold = 1;
    for (int i = 0; i < 5; i++) do_write(8'h70 + 8'(i), -1, -1);
    issue_write(8'h7F, -1, -1);
    repeat (2) @(posedge clock);
    manual_req++;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clock); #1;
        if (tx_in.mem_valid) begin seen = 1; break; end
      end
      chk("reset_setup_tx_seen", 32'(seen), 32'd1);
    end
    #2 reset = 1'b1;
    #1 chk_outputs_zero("async_reset");
    exp_bus.delete();
    exp_tx.delete();
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    base = n_wr_done - n_tx_seen;
    txs0 = n_tx_seen;
    repeat (30) @(posedge clock);
    #1 chk("no_tx_after_reset", n_tx_seen, txs0);
    do_read(1'b0);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO that sits directly upstream of the UART transmitter. It accepts CPU write transactions on the memory bus and queues the low byte of each write. It drains the queue into `uart_tx` one byte at a time using that block's `mem_valid` / `mem_ready` handshake. Reads on the bus return FIFO status, so software can write bursts without polling per character.

## Interface
- `depth`, default 16: FIFO entries; power of two, minimum 2.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `bus_in`  in  `mem_in_type`: CPU side. Uses `mem_valid`, `mem_wstrb`, `mem_wdata[7:0]`.
- `bus_out`  out  `mem_out_type`: CPU side. Carries `mem_ready`, `mem_rdata`, `mem_error`.
- `tx_in`  out  `mem_in_type`: request to `uart_tx`.
- `tx_out`  in  `mem_out_type`: response from `uart_tx`. Only `mem_ready` is used.

## Operation
- Storage: `depth` x 8-bit array, read pointer, write pointer, and a `count` register of width log2(depth)+1.
  - Pointers wrap modulo `depth`.
- Write request (`mem_valid=1`, `|mem_wstrb=1`): latched into a single pending slot (`pend_valid`, `pend_data = mem_wdata[7:0]`).
  - If `count < depth`, the byte is pushed on the next edge, `pend_valid` clears, and `bus_out.mem_ready` pulses for 1 cycle.
  - If full, the request stays pending and is retried every cycle. `mem_ready` pulses the cycle after the push.
  - Writes never error.
- Read request (`mem_valid=1`, `mem_wstrb=0`): no FIFO change. Returns the following in `mem_rdata`, with `mem_ready` pulsed:
  - bit0 = full (`count==depth`);
  - bit1 = empty (`count==0`);
  - bit2 = busy (drain FSM not IDLE);
  - bits[15:8] = count, zero-extended;
  - all other bits 0.
- `mem_valid` arriving while `pend_valid=1` is ignored. The bus master issues in order and waits for `mem_ready`.
- `bus_out.mem_error` is constant 0.
- Drain FSM:
  - IDLE: if `count>0`, go to SEND.
  - SEND: `tx_in.mem_valid=1`, `tx_in.mem_wstrb=4'b0001`, `tx_in.mem_wdata={24'b0, head byte}` for exactly 1 cycle. Head is popped on this edge. Go to WAIT.
  - WAIT: hold `tx_in.mem_valid=0`. On `tx_out.mem_ready=1`, go to IDLE.
- Simultaneous push and pop in one cycle: `count` is unchanged and both pointers advance.
  - Push eligibility uses the registered `count`, so a full FIFO accepts the pending byte one cycle after the pop.
- Byte order on `tx_in` equals the bus write order. No byte is dropped or duplicated.
- Reset (asynchronous, any time):
  - `count`, both pointers and `pend_valid` go to 0; state goes to IDLE.
  - All `bus_out` and `tx_in` fields go to 0.
  - Queued bytes are discarded. Array contents are don't-care.
  - `uart_tx` must be reset together with this block.

## Timing
- Write to non-full FIFO: `mem_valid` in cycle N, push at edge N+1, `mem_ready` high in cycle N+1.
- Read: `mem_valid` in cycle N, `mem_rdata` and `mem_ready` valid in cycle N+1 only. `mem_rdata` is 0 whenever `mem_ready=0`.
- Empty FIFO, write in cycle N: byte is in FIFO at N+1, FSM in SEND at N+2, `tx_in.mem_valid` high in cycle N+2.
- Back-to-back transmit: `tx_out.mem_ready` in cycle M gives IDLE at M+1 and SEND (next `mem_valid`) at M+2.
- Drain issues at most one byte per `uart_tx` frame. `tx_in.mem_valid` is never high in two consecutive cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: all outputs 0. A status read returns `mem_rdata=32'h0000_0002` (empty) one cycle after `mem_valid`.
- Single write of 8'h41 to an empty FIFO: `bus_out.mem_ready` at N+1; `tx_in.mem_valid` with `mem_wdata=32'h41` at N+2 for 1 cycle; FSM in WAIT until the bench pulses `tx_out.mem_ready`.
- Burst of 5 writes 8'h30..8'h34 with a bench `uart_tx` model that acks 20 cycles after each request: `tx_in` carries 30,31,32,33,34 in order, each issued 2 cycles after the previous ack. A status read mid-burst shows the correct count in bits[15:8].
- Fill with `depth`=4 while the ack is withheld:
  - the first byte goes to WAIT and 4 more fill the FIFO (status 32'h0000_0405);
  - the 6th write gets no `mem_ready` until an ack arrives;
  - then it is acked 1 cycle after the pop;
  - all 6 bytes come out in order.
- Wrap-around: 3 x `depth` bytes streamed with random ack delays 0-10 cycles. Output order matches input order and count returns to 0 (status 32'h0000_0002).
- Asynchronous reset asserted mid-cycle with 3 bytes queued and a pending write: outputs go to 0 immediately; after release, status reads empty and no further `tx_in.mem_valid` occurs.
